// File: rtl/hd44780_byte_tx_if.sv
// Request/response channel between the LCD sequencer and the byte write engine.
interface hd44780_byte_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_nibble_only;
  logic       done;

  modport master (
    output in_valid, in_rs, in_data, in_nibble_only,
    input  in_ready, done
  );

  modport slave (
    input  in_valid, in_rs, in_data, in_nibble_only,
    output in_ready, done
  );
endinterface

// File: rtl/hd44780_byte_tx.sv
// HD44780 4-bit bus byte writer: two E-strobed nibbles (or one for mode entry),
// then a fixed controller execution wait before the next byte is accepted.
module hd44780_byte_tx #(
  parameter int unsigned E_CYCLES         = 2,
  parameter int unsigned GAP_CYCLES       = 2,
  parameter int unsigned EXEC_CYCLES      = 20,
  parameter int unsigned LONG_EXEC_CYCLES = 2500,
  parameter int unsigned CNT_W            = 12
) (
  input  logic               clk,
  input  logic               rst,
  hd44780_byte_tx_if.slave   req,
  output logic               e,
  output logic               rs,
  output logic [3:0]         db
);

  typedef enum logic [2:0] {IDLE, HI_E, GAP, LO_E, EXEC} state_t;

  localparam logic [CNT_W-1:0] E_LOAD    = CNT_W'(E_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD = CNT_W'(LONG_EXEC_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [3:0]       db_q, db_d;
  logic [3:0]       lo_q, lo_d;
  logic             nib_q, nib_d;
  logic             long_q, long_d;
  logic             done_q, done_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 4'h0;
      lo_q    <= 4'h0;
      nib_q   <= 1'b0;
      long_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      lo_q    <= lo_d;
      nib_q   <= nib_d;
      long_q  <= long_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    db_d    = db_q;
    lo_d    = lo_q;
    nib_d   = nib_q;
    long_d  = long_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req.in_valid) begin
          // high nibble goes straight to the pins; only the low nibble is kept
          rs_d    = req.in_rs;
          db_d    = req.in_data[7:4];
          lo_d    = req.in_data[3:0];
          nib_d   = req.in_nibble_only;
          long_d  = !req.in_rs && (req.in_data[7:2] == 6'b0) && !req.in_nibble_only;
          e_d     = 1'b1;
          cnt_d   = E_LOAD;
          state_d = HI_E;
        end
      end
      HI_E: begin
        if (cnt_zero) begin
          e_d = 1'b0;
          if (nib_q) begin
            cnt_d   = EXEC_LOAD;
            state_d = EXEC;
          end else begin
            cnt_d   = GAP_LOAD;
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_zero) begin
          db_d    = lo_q;
          e_d     = 1'b1;
          cnt_d   = E_LOAD;
          state_d = LO_E;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LO_E: begin
        if (cnt_zero) begin
          e_d     = 1'b0;
          cnt_d   = long_q ? LONG_LOAD : EXEC_LOAD;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EXEC: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        e_d     = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign req.in_ready = (state_q == IDLE);
  assign req.done     = done_q;
  assign e            = e_q;
  assign rs           = rs_q;
  assign db           = db_q;

endmodule

// File: tb/tb_hd44780_byte_tx.sv
// Bench for hd44780_byte_tx: cycle-offset waveform model compared every cycle,
// plus literal latency/pulse-count checks and randomized requests.
module tb_hd44780_byte_tx;
  localparam int E = 2;
  localparam int G = 2;
  localparam int X = 20;
  localparam int L = 2500;

  logic       clk = 1'b0;
  logic       rst;
  logic       e, rs;
  logic [3:0] db;

  hd44780_byte_tx_if bus ();

  hd44780_byte_tx #(
    .E_CYCLES(E), .GAP_CYCLES(G), .EXEC_CYCLES(X), .LONG_EXEC_CYCLES(L), .CNT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .req(bus), .e(e), .rs(rs), .db(db)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: outputs are a function of cycles elapsed since the accept edge
  logic       m_e, m_rs, m_done, m_ready;
  logic [3:0] m_db;
  bit         m_busy = 0;
  bit         m_nib;
  int         m_k, m_n;
  logic [7:0] m_data;
  int         cyc = 0, acc_cyc = 0, done_cyc = 0, acc_cnt = 0, done_cnt = 0;
  int         e_rises = 0;
  logic       e_prev = 1'b0;
  bit         chk_en = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_e = 0; m_rs = 0; m_db = 4'h0; m_done = 0; m_ready = 1;
    end else if (m_ready && bus.in_valid) begin
      m_busy  = 1;
      m_k     = 0;
      m_data  = bus.in_data;
      m_nib   = bus.in_nibble_only;
      m_rs    = bus.in_rs;
      m_ready = 0;
      m_done  = 0;
      if (m_nib) m_n = E + X;
      else if (!bus.in_rs && bus.in_data < 8'd4) m_n = 2*E + G + L;
      else m_n = 2*E + G + X;
      acc_cyc = cyc;
      acc_cnt++;
      m_e  = 1;
      m_db = m_data[7:4];
    end else if (m_busy) begin
      m_k++;
      if (m_k == m_n) begin
        m_busy = 0; m_ready = 1; m_done = 1; m_e = 0;
        done_cyc = cyc;
        done_cnt++;
      end else begin
        m_e  = (m_k < E) || (!m_nib && m_k >= E + G && m_k < 2*E + G);
        m_db = (m_nib || m_k < E + G) ? m_data[7:4] : m_data[3:0];
      end
    end else begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({e, rs, db, bus.done, bus.in_ready} !== {m_e, m_rs, m_db, m_done, m_ready}) begin
        fails++;
        $display("FAIL pins@cyc%0d got e=%b rs=%b db=%h done=%b rdy=%b want e=%b rs=%b db=%h done=%b rdy=%b",
                 cyc, e, rs, db, bus.done, bus.in_ready, m_e, m_rs, m_db, m_done, m_ready);
      end
      if (e && !e_prev) e_rises++;
      e_prev = e;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_acc(input int prev, input string name);
    int t = 0;
    while (acc_cnt == prev && t < 100) begin @(negedge clk); t++; end
    if (acc_cnt == prev) chk({name, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input int prev, input string name);
    int t = 0;
    while (done_cnt == prev && t < 3000) begin @(negedge clk); t++; end
    if (done_cnt == prev) chk({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic send(input bit r, input logic [7:0] d, input bit nib, input int exp_n,
                      input string name);
    int pa, pd;
    pa = acc_cnt;
    pd = done_cnt;
    bus.in_valid = 1; bus.in_rs = r; bus.in_data = d; bus.in_nibble_only = nib;
    wait_acc(pa, name);
    bus.in_valid = 0;
    bus.in_rs = 1'($urandom);
    bus.in_data = 8'($urandom);
    bus.in_nibble_only = 1'($urandom);
    wait_done(pd, name);
    if (exp_n > 0) chk({name, "_latency"}, done_cyc - acc_cyc, exp_n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int pa, pd, base, d1;
    logic [7:0] rd;
    rst = 1;
    bus.in_valid = 0; bus.in_rs = 0; bus.in_data = 8'h00; bus.in_nibble_only = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("reset_e", int'(e), 0);
    chk("reset_db", int'(db), 0);
    chk("reset_rdy", int'(bus.in_ready), 1);
    rst = 0;
    @(negedge clk);

    send(0, 8'h28, 0, 26,   "fn_set_28");
    send(1, 8'h41, 0, 26,   "data_41");
    send(0, 8'h01, 0, 2506, "clear_01");
    send(0, 8'h02, 0, 2506, "home_02");
    send(1, 8'h01, 0, 26,   "data_01");
    send(0, 8'h04, 0, 26,   "entry_04");
    send(0, 8'h30, 1, 22,   "nib_30");
    repeat (3) @(negedge clk);

    // back-to-back with valid held high
    base = e_rises;
    pa = acc_cnt; pd = done_cnt;
    bus.in_valid = 1; bus.in_rs = 0; bus.in_data = 8'h0E; bus.in_nibble_only = 0;
    wait_acc(pa, "b2b_first");
    bus.in_data = 8'h06;
    pa = acc_cnt;
    wait_done(pd, "b2b_first");
    d1 = done_cyc;
    pd = done_cnt;
    wait_acc(pa, "b2b_second");
    chk("b2b_accept_in_done_cycle", acc_cyc - d1, 1);
    bus.in_valid = 0;
    wait_done(pd, "b2b_second");
    @(negedge clk);
    chk("b2b_e_pulses", e_rises - base, 4);

    // reset during the low-nibble strobe
    pa = acc_cnt;
    bus.in_valid = 1; bus.in_rs = 0; bus.in_data = 8'h28; bus.in_nibble_only = 0;
    wait_acc(pa, "rst_mid");
    bus.in_valid = 0;
    repeat (4) @(negedge clk);
    chk("rst_mid_e_before", int'(e), 1);
    chk("rst_mid_db_before", int'(db), 8);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_e", int'(e), 0);
    chk("rst_mid_db", int'(db), 0);
    chk("rst_mid_rs", int'(rs), 0);
    chk("rst_mid_rdy", int'(bus.in_ready), 1);
    send(0, 8'h0C, 0, 26, "after_rst_0C");

    for (int i = 0; i < 60; i++) begin
      rd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rd = rd & 8'h07;
      send(1'($urandom), rd, ($urandom_range(0, 3) == 0), -1, "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
